// File: rtl/carfield_cfg_regbus_decoder_if.sv
// Host RegBus request/response channel plus the per-target config bus seen by the decoder.
// slave = decoder view, master = host/target side view.
interface carfield_cfg_regbus_decoder_if #(
  parameter int unsigned NumRegions = 4,
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned DataWidth  = 32
);
  logic                           req_valid_i;
  logic                           req_ready_o;
  logic [AddrWidth-1:0]           req_addr_i;
  logic                           req_write_i;
  logic [DataWidth-1:0]           req_wdata_i;
  logic [DataWidth/8-1:0]         req_wstrb_i;
  logic                           rsp_valid_o;
  logic                           rsp_ready_i;
  logic [DataWidth-1:0]           rsp_rdata_o;
  logic                           rsp_error_o;
  logic [NumRegions-1:0]          tgt_valid_o;
  logic [NumRegions-1:0]          tgt_ready_i;
  logic [AddrWidth-1:0]           tgt_addr_o;
  logic                           tgt_write_o;
  logic [DataWidth-1:0]           tgt_wdata_o;
  logic [DataWidth/8-1:0]         tgt_wstrb_o;
  logic [NumRegions*DataWidth-1:0] tgt_rdata_i;
  logic [NumRegions-1:0]          tgt_error_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_wstrb_i,
    input  rsp_ready_i, tgt_ready_i, tgt_rdata_i, tgt_error_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
    output tgt_valid_o, tgt_addr_o, tgt_write_o, tgt_wdata_o, tgt_wstrb_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_wstrb_i,
    output rsp_ready_i, tgt_ready_i, tgt_rdata_i, tgt_error_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
    input  tgt_valid_o, tgt_addr_o, tgt_write_o, tgt_wdata_o, tgt_wstrb_o
  );
endinterface

// File: rtl/carfield_cfg_regbus_decoder.sv
// Single-outstanding RegBus responder routing each request to one Carfield config target.
// Define CARFIELD_DECODE_TIMEOUT_EN to bound the target wait with a TimeoutCycles counter.
module carfield_cfg_regbus_decoder #(
  parameter int unsigned NumRegions = 4,
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned DataWidth  = 32,
  parameter logic [NumRegions-1:0][AddrWidth-1:0] RegionBase = {
    48'h0000_200B_0000, 48'h0000_200A_0000, 48'h0000_2002_0000, 48'h0000_2001_0000},
  parameter logic [NumRegions-1:0][AddrWidth-1:0] RegionSize = {4{48'h0000_0000_1000}},
  parameter logic [NumRegions-1:0] RegionEnable  = 4'b1111,
  parameter logic [DataWidth-1:0]  ErrData       = 32'hBADCAB1E,
  parameter int unsigned           TimeoutCycles = 256
) (
  input logic clk_i,
  input logic rst_ni,
  carfield_cfg_regbus_decoder_if.slave bus
);

  localparam int unsigned IdxW  = (NumRegions > 1) ? $clog2(NumRegions) : 1;
  localparam int unsigned StrbW = DataWidth / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [DataWidth-1:0]  r_rsp_rdata;
  logic                  r_rsp_error;
  logic [NumRegions-1:0] r_tgt_valid;
  logic [NumRegions-1:0] w_tgt_valid_next;
  logic [AddrWidth-1:0]  r_addr;
  logic                  r_write;
  logic [DataWidth-1:0]  r_wdata;
  logic [StrbW-1:0]      r_wstrb;
  logic [IdxW-1:0]       r_idx;

  logic [NumRegions-1:0] w_hit_vec;
  logic                  w_hit;
  logic [IdxW-1:0]       w_idx;
  logic [IdxW-1:0]       w_sel_idx;
  logic                  w_accept;
  logic                  w_capture_tgt;
  logic                  w_timeout;
  logic                  w_expired;
  logic                  w_sel_ready;
  logic                  w_sel_error;
  logic [DataWidth-1:0]  w_sel_rdata;

  // Region match on AddrWidth+1 bits so base+size never wraps; lowest index wins.
  always_comb begin
    w_hit_vec = '0;
    w_hit     = 1'b0;
    w_idx     = '0;
    for (int i = 0; i < int'(NumRegions); i++) begin
      w_hit_vec[i] = RegionEnable[i]
                  && ({1'b0, bus.req_addr_i} >= {1'b0, RegionBase[i]})
                  && ({1'b0, bus.req_addr_i} <  ({1'b0, RegionBase[i]} + {1'b0, RegionSize[i]}));
    end
    for (int i = int'(NumRegions) - 1; i >= 0; i--) begin
      w_idx = w_hit_vec[i] ? IdxW'(i) : w_idx;
      w_hit = w_hit | w_hit_vec[i];
    end
  end

  assign w_sel_ready = bus.tgt_ready_i[r_idx];
  assign w_sel_error = bus.tgt_error_i[r_idx];
  assign w_sel_rdata = bus.tgt_rdata_i[DataWidth*r_idx +: DataWidth];

`ifdef CARFIELD_DECODE_TIMEOUT_EN
  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  logic [CntW-1:0] r_cnt;

  assign w_expired = (r_cnt == CntW'(TimeoutCycles - 1));

  // Wait counter: zero outside FWD, so it restarts on every FWD entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (r_state == ST_FWD) begin
      r_cnt <= r_cnt + CntW'(1);
    end else begin
      r_cnt <= '0;
    end
  end
`else
  logic w_unused_cfg;
  assign w_expired    = 1'b0;
  assign w_unused_cfg = (TimeoutCycles > 32'd0);
`endif

  // Next-state decode and next one-hot target strobe.
  always_comb begin
    w_state_next     = r_state;
    w_accept         = 1'b0;
    w_capture_tgt    = 1'b0;
    w_timeout        = 1'b0;
    w_tgt_valid_next = '0;
    w_sel_idx        = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid_i && r_req_ready) begin
          w_accept     = 1'b1;
          w_state_next = w_hit ? ST_FWD : ST_RSP;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_FWD: begin
        if (w_sel_ready) begin
          w_capture_tgt = 1'b1;
          w_state_next  = ST_RSP;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_state_next = ST_RSP;
        end else begin
          w_state_next = ST_FWD;
        end
      end
      ST_RSP: begin
        if (bus.rsp_ready_i) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_RSP;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    w_sel_idx = w_accept ? w_idx : r_idx;
    if (w_state_next == ST_FWD) begin
      w_tgt_valid_next[w_sel_idx] = 1'b1;
    end else begin
      w_tgt_valid_next = '0;
    end
  end

  // State, captured request and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
      r_tgt_valid <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_idx       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_req_ready <= (w_state_next == ST_IDLE);
      r_rsp_valid <= (w_state_next == ST_RSP);
      r_tgt_valid <= w_tgt_valid_next;
      if (w_accept) begin
        r_addr  <= bus.req_addr_i;
        r_write <= bus.req_write_i;
        r_wdata <= bus.req_wdata_i;
        r_wstrb <= bus.req_wstrb_i;
        r_idx   <= w_idx;
      end
      if ((w_accept && !w_hit) || w_timeout) begin
        r_rsp_rdata <= ErrData;
        r_rsp_error <= 1'b1;
      end else if (w_capture_tgt) begin
        r_rsp_rdata <= w_sel_rdata;
        r_rsp_error <= w_sel_error;
      end
    end
  end

  assign bus.req_ready_o = r_req_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.rsp_error_o = r_rsp_error;
  assign bus.tgt_valid_o = r_tgt_valid;
  assign bus.tgt_addr_o  = r_addr;
  assign bus.tgt_write_o = r_write;
  assign bus.tgt_wdata_o = r_wdata;
  assign bus.tgt_wstrb_o = r_wstrb;

endmodule
